// File: rtl/mips_pkg.sv
// Shared opcodes, instruction-class decode and field positions for the
// mips_32 pipeline and its ALU.
package mips_pkg;

    localparam logic [5:0] OP_ADD   = 6'd0;
    localparam logic [5:0] OP_SUB   = 6'd1;
    localparam logic [5:0] OP_AND   = 6'd2;
    localparam logic [5:0] OP_OR    = 6'd3;
    localparam logic [5:0] OP_SLT   = 6'd4;
    localparam logic [5:0] OP_MUL   = 6'd5;
    localparam logic [5:0] OP_LW    = 6'd8;
    localparam logic [5:0] OP_SW    = 6'd9;
    localparam logic [5:0] OP_ADDI  = 6'd10;
    localparam logic [5:0] OP_SUBI  = 6'd11;
    localparam logic [5:0] OP_SLTI  = 6'd12;
    localparam logic [5:0] OP_BNEQZ = 6'd13;
    localparam logic [5:0] OP_BEQZ  = 6'd14;
    localparam logic [5:0] OP_HLT   = 6'd63;

    localparam int OP_HI  = 31, OP_LO  = 26;
    localparam int RS_HI  = 25, RS_LO  = 21;
    localparam int RT_HI  = 20, RT_LO  = 16;
    localparam int RD_HI  = 15, RD_LO  = 11;
    localparam int IMM_HI = 15, IMM_LO = 0;

    typedef enum logic [2:0] {RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT, NOP} cls_e;

    function automatic cls_e decode_cls(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: return RR_ALU;
            OP_ADDI, OP_SUBI, OP_SLTI:                     return RM_ALU;
            OP_LW:                                         return LOAD;
            OP_SW:                                         return STORE;
            OP_BNEQZ, OP_BEQZ:                             return BRANCH;
            OP_HLT:                                        return HALT;
            default:                                       return NOP;
        endcase
    endfunction

    function automatic logic reads_rs(input cls_e c);
        return (c == RR_ALU) || (c == RM_ALU) || (c == LOAD) || (c == STORE) || (c == BRANCH);
    endfunction

    function automatic logic reads_rt(input cls_e c);
        return (c == RR_ALU) || (c == STORE);
    endfunction

endpackage

// File: rtl/mips_alu.sv
// Combinational ALU; zero reports whether operand a is zero, which is what
// the branch tests need.
module mips_alu
    import mips_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        zero
);

    always_comb begin
        result = a;
        case (opcode)
            OP_ADD, OP_ADDI, OP_LW, OP_SW: result = a + b;
            OP_SUB, OP_SUBI:               result = a - b;
            OP_AND:                        result = a & b;
            OP_OR:                         result = a | b;
            OP_SLT, OP_SLTI:               result = {31'd0, $signed(a) < $signed(b)};
            OP_MUL:                        result = a * b;
            default:                       result = a;
        endcase
    end

    assign zero = (a == 32'd0);

endmodule

// File: rtl/mips_32.sv
// Five-stage in-order MIPS32-subset core with unified word memory, EX-stage
// branch resolution, operand forwarding and a one-cycle load-use stall.
module mips_32
    import mips_pkg::*;
#(
    parameter int MEM_DEPTH = 1024,
    parameter int AW        = 10
) (
    input  logic clk,
    input  logic rst_n,
    output logic halted
);

    typedef struct packed {
        logic          vld;
        logic [31:0]   ir;
        logic [AW-1:0] npc;
    } ifid_t;

    typedef struct packed {
        logic          vld;
        cls_e          cls;
        logic [5:0]    op;
        logic [4:0]    rs;
        logic [4:0]    rt;
        logic [4:0]    dest;
        logic          wen;
        logic [31:0]   a;
        logic [31:0]   b;
        logic [31:0]   imm;
        logic [AW-1:0] npc;
    } idex_t;

    typedef struct packed {
        logic        vld;
        cls_e        cls;
        logic [4:0]  dest;
        logic        wen;
        logic [31:0] res;
        logic [31:0] sdata;
    } exmem_t;

    typedef struct packed {
        logic        vld;
        cls_e        cls;
        logic [4:0]  dest;
        logic        wen;
        logic [31:0] res;
    } memwb_t;

    logic [31:0]   REG [0:31];
    logic [31:0]   MEM [0:MEM_DEPTH-1];
    logic [AW-1:0] PC, pc_d;
    logic          HALTED, halted_d;
    logic          TAKEN_BRANCH;
    logic          stop_q, stop_d;
    ifid_t         if_id_q, if_id_d;
    idex_t         id_ex_q, id_ex_d;
    exmem_t        ex_mem_q, ex_mem_d;
    memwb_t        mem_wb_q, mem_wb_d;

    logic [5:0]    id_op;
    logic [4:0]    id_rs, id_rt, id_rd;
    cls_e          id_cls;
    logic [31:0]   id_imm, id_a, id_b;
    logic          wb_we, lu_stall, id_hlt;
    logic [31:0]   ex_a, ex_b, alu_b, alu_res, mem_rd;
    logic          alu_zero, taken;
    logic [AW-1:0] target;

    assign id_op  = if_id_q.ir[OP_HI:OP_LO];
    assign id_rs  = if_id_q.ir[RS_HI:RS_LO];
    assign id_rt  = if_id_q.ir[RT_HI:RT_LO];
    assign id_rd  = if_id_q.ir[RD_HI:RD_LO];
    assign id_cls = decode_cls(id_op);
    assign id_imm = {{16{if_id_q.ir[IMM_HI]}}, if_id_q.ir[IMM_HI:IMM_LO]};
    assign id_hlt = if_id_q.vld && (id_cls == HALT);

    // Write-through register file: the WB result bypasses into the ID read.
    assign wb_we = mem_wb_q.vld && mem_wb_q.wen && (mem_wb_q.dest != 5'd0);
    assign id_a  = (id_rs == 5'd0) ? 32'd0 :
                   (wb_we && mem_wb_q.dest == id_rs) ? mem_wb_q.res : REG[id_rs];
    assign id_b  = (id_rt == 5'd0) ? 32'd0 :
                   (wb_we && mem_wb_q.dest == id_rt) ? mem_wb_q.res : REG[id_rt];

    assign lu_stall = id_ex_q.vld && (id_ex_q.cls == LOAD) && (id_ex_q.dest != 5'd0) && if_id_q.vld &&
                      ((reads_rs(id_cls) && id_rs == id_ex_q.dest) ||
                       (reads_rt(id_cls) && id_rt == id_ex_q.dest));

    // A load in EX/MEM has no data yet; that case is covered by the stall.
    function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] dflt,
                                        input exmem_t em, input memwb_t mw);
        if (src != 5'd0 && em.vld && em.wen && em.cls != LOAD && em.dest == src) return em.res;
        if (src != 5'd0 && mw.vld && mw.wen && mw.dest == src) return mw.res;
        return dflt;
    endfunction

    assign ex_a   = fwd(id_ex_q.rs, id_ex_q.a, ex_mem_q, mem_wb_q);
    assign ex_b   = fwd(id_ex_q.rt, id_ex_q.b, ex_mem_q, mem_wb_q);
    assign alu_b  = (id_ex_q.cls == RR_ALU) ? ex_b : id_ex_q.imm;
    assign taken  = id_ex_q.vld && (id_ex_q.cls == BRANCH) && ((id_ex_q.op == OP_BEQZ) == alu_zero);
    assign target = id_ex_q.npc + id_ex_q.imm[AW-1:0];
    assign mem_rd = MEM[ex_mem_q.res[AW-1:0]];

    mips_alu u_alu (
        .opcode (id_ex_q.op),
        .a      (ex_a),
        .b      (alu_b),
        .result (alu_res),
        .zero   (alu_zero)
    );

    always_comb begin
        pc_d     = PC;
        if_id_d  = if_id_q;
        id_ex_d  = '0;
        stop_d   = stop_q | (id_hlt & ~taken);
        halted_d = HALTED | (mem_wb_q.vld & (mem_wb_q.cls == HALT));
        if (taken) begin
            pc_d    = target;
            if_id_d = '0;
        end else if (!lu_stall) begin
            id_ex_d = '{vld: if_id_q.vld, cls: id_cls, op: id_op, rs: id_rs, rt: id_rt,
                        dest: (id_cls == RR_ALU) ? id_rd : id_rt,
                        wen: (id_cls == RR_ALU) || (id_cls == RM_ALU) || (id_cls == LOAD),
                        a: id_a, b: id_b, imm: id_imm, npc: if_id_q.npc};
            if (stop_q || id_hlt) begin
                if_id_d = '0;
            end else begin
                if_id_d = '{vld: 1'b1, ir: MEM[PC], npc: PC + 1'b1};
                pc_d    = PC + 1'b1;
            end
        end
        ex_mem_d = '{vld: id_ex_q.vld, cls: id_ex_q.cls, dest: id_ex_q.dest, wen: id_ex_q.wen,
                     res: alu_res, sdata: ex_b};
        mem_wb_d = '{vld: ex_mem_q.vld, cls: ex_mem_q.cls, dest: ex_mem_q.dest, wen: ex_mem_q.wen,
                     res: (ex_mem_q.cls == LOAD) ? mem_rd : ex_mem_q.res};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PC           <= '0;
            HALTED       <= 1'b0;
            TAKEN_BRANCH <= 1'b0;
            stop_q       <= 1'b0;
            if_id_q      <= '0;
            id_ex_q      <= '0;
            ex_mem_q     <= '0;
            mem_wb_q     <= '0;
        end else begin
            PC           <= pc_d;
            HALTED       <= halted_d;
            TAKEN_BRANCH <= taken;
            stop_q       <= stop_d;
            if_id_q      <= if_id_d;
            id_ex_q      <= id_ex_d;
            ex_mem_q     <= ex_mem_d;
            mem_wb_q     <= mem_wb_d;
        end
    end

    // Architectural storage survives reset so preloads and committed writes stay.
    always_ff @(posedge clk) begin
        if (wb_we) REG[mem_wb_q.dest] <= mem_wb_q.res;
        if (ex_mem_q.vld && ex_mem_q.cls == STORE) MEM[ex_mem_q.res[AW-1:0]] <= ex_mem_q.sdata;
    end

    assign halted = HALTED;

endmodule

// File: tb/tb_mips_32.sv
// Directed bench for mips_32: single-instruction vector table plus hand-written
// programs for forwarding, load-use, branch loop, halt and mid-run reset.
module tb_mips_32;

    localparam logic [5:0] OP_ADD = 6'd0, OP_SUB = 6'd1, OP_AND = 6'd2, OP_OR = 6'd3;
    localparam logic [5:0] OP_SLT = 6'd4, OP_MUL = 6'd5, OP_LW = 6'd8, OP_SW = 6'd9;
    localparam logic [5:0] OP_ADDI = 6'd10, OP_SUBI = 6'd11, OP_SLTI = 6'd12, OP_BNEQZ = 6'd13;
    localparam logic [31:0] HALT_W = 32'hFC00_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic halted;

    mips_32 dut (.clk(clk), .rst_n(rst_n), .halted(halted));

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int taken_seen = 0;

    always @(negedge clk) if (dut.TAKEN_BRANCH) taken_seen++;

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [15:0] imm;
        logic [31:0] exp;
    } vec_t;
    vec_t vq[$];

    function automatic logic [31:0] r_i(input logic [5:0] op, input logic [4:0] rd, rs, rt);
        return {op, rs, rt, rd, 11'd0};
    endfunction

    function automatic logic [31:0] i_i(input logic [5:0] op, input logic [4:0] rt, rs, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic add_vec(input string n, input logic [5:0] op, input logic [4:0] rd,
                           input logic [31:0] a, input logic [31:0] b, input logic [15:0] imm,
                           input logic [31:0] e);
        vec_t v;
        v.name = n; v.op = op; v.rd = rd; v.a = a; v.b = b; v.imm = imm; v.exp = e;
        vq.push_back(v);
    endtask

    task automatic hold_reset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 256; i++) dut.MEM[i] = 32'd0;
        for (int i = 0; i < 32; i++) dut.REG[i] = 32'(i);
    endtask

    task automatic run(input string n, input int maxc, output int cyc);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        while (!halted && cyc < maxc) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        chk({n, " halted"}, {31'd0, halted}, 32'd1);
    endtask

    task automatic load_fact();
        dut.MEM[0] = i_i(OP_LW, 5'd3, 5'd10, 16'd0);
        dut.MEM[1] = i_i(OP_ADDI, 5'd2, 5'd0, 16'd1);
        dut.MEM[2] = r_i(OP_MUL, 5'd2, 5'd2, 5'd3);
        dut.MEM[3] = i_i(OP_SUBI, 5'd3, 5'd3, 16'd1);
        dut.MEM[4] = i_i(OP_BNEQZ, 5'd0, 5'd3, 16'hFFFD);
        dut.MEM[5] = i_i(OP_ADDI, 5'd20, 5'd20, 16'd1);
        dut.MEM[6] = i_i(OP_ADDI, 5'd21, 5'd21, 16'd1);
        dut.MEM[7] = i_i(OP_SW, 5'd2, 5'd10, 16'hFFFE);
        dut.MEM[8] = HALT_W;
        dut.MEM[200] = 32'd7;
        dut.REG[10] = 32'd200;
        dut.REG[2] = 32'd0;
        dut.REG[3] = 32'd0;
        dut.REG[20] = 32'd0;
        dut.REG[21] = 32'd0;
    endtask

    initial begin
        int cyc, cyc_nodep, t0;

        hold_reset();
        #1;
        chk("rst halted", {31'd0, halted}, 32'd0);
        chk("rst pc", 32'(dut.PC), 32'd0);
        chk("rst taken", {31'd0, dut.TAKEN_BRANCH}, 32'd0);

        add_vec("add",      OP_ADD,  3, 32'd5,         32'd7,         16'd0,     32'd12);
        add_vec("add wrap", OP_ADD,  3, 32'hFFFF_FFFF, 32'd2,         16'd0,     32'd1);
        add_vec("sub neg",  OP_SUB,  3, 32'd3,         32'd5,         16'd0,     32'hFFFF_FFFE);
        add_vec("and",      OP_AND,  3, 32'hF0F0,      32'hFF00,      16'd0,     32'hF000);
        add_vec("or",       OP_OR,   3, 32'hF0F0,      32'h0F0F,      16'd0,     32'hFFFF);
        add_vec("slt -1<1", OP_SLT,  3, 32'hFFFF_FFFF, 32'd1,         16'd0,     32'd1);
        add_vec("slt 1<-1", OP_SLT,  3, 32'd1,         32'hFFFF_FFFF, 16'd0,     32'd0);
        add_vec("mul",      OP_MUL,  3, 32'd7,         32'd6,         16'd0,     32'd42);
        add_vec("mul low",  OP_MUL,  3, 32'h0001_0001, 32'h0001_0001, 16'd0,     32'h0002_0001);
        add_vec("addi neg", OP_ADDI, 3, 32'd10,        32'd0,         16'hFFFD,  32'd7);
        add_vec("subi wrap",OP_SUBI, 3, 32'd0,         32'd0,         16'd1,     32'hFFFF_FFFF);
        add_vec("slti neg", OP_SLTI, 3, 32'hFFFF_FFFB, 32'd0,         16'hFFFC,  32'd1);
        add_vec("slti eq",  OP_SLTI, 3, 32'd5,         32'd0,         16'd5,     32'd0);
        add_vec("r0 write", OP_ADD,  0, 32'd5,         32'd7,         16'd0,     32'd0);
        add_vec("nop op7",  6'd7,    3, 32'd1,         32'd2,         16'd0,     32'hDEAD_BEEF);

        foreach (vq[i]) begin
            hold_reset();
            dut.REG[1] = vq[i].a;
            dut.REG[2] = vq[i].b;
            dut.REG[3] = 32'hDEAD_BEEF;
            if (vq[i].op >= OP_ADDI && vq[i].op <= OP_SLTI)
                dut.MEM[0] = i_i(vq[i].op, vq[i].rd, 5'd1, vq[i].imm);
            else
                dut.MEM[0] = r_i(vq[i].op, vq[i].rd, 5'd1, 5'd2);
            dut.MEM[1] = HALT_W;
            run(vq[i].name, 50, cyc);
            chk(vq[i].name, dut.REG[vq[i].rd], vq[i].exp);
        end

        // memory/immediate chain with spacers
        hold_reset();
        dut.MEM[120] = 32'd85;
        dut.MEM[0] = i_i(OP_ADDI, 5'd1, 5'd0, 16'd120);
        dut.MEM[1] = r_i(OP_OR, 5'd3, 5'd3, 5'd3);
        dut.MEM[2] = i_i(OP_LW, 5'd2, 5'd1, 16'd0);
        dut.MEM[3] = r_i(OP_OR, 5'd3, 5'd3, 5'd3);
        dut.MEM[4] = i_i(OP_ADDI, 5'd2, 5'd2, 16'd45);
        dut.MEM[5] = r_i(OP_OR, 5'd3, 5'd3, 5'd3);
        dut.MEM[6] = i_i(OP_SW, 5'd2, 5'd1, 16'd1);
        dut.MEM[7] = HALT_W;
        run("chain", 100, cyc);
        chk("chain mem121", dut.MEM[121], 32'd130);
        chk("chain mem120", dut.MEM[120], 32'd85);
        chk("chain r1", dut.REG[1], 32'd120);
        chk("chain r2", dut.REG[2], 32'd130);

        // back-to-back dependencies
        hold_reset();
        dut.MEM[0] = i_i(OP_ADDI, 5'd1, 5'd0, 16'd10);
        dut.MEM[1] = i_i(OP_ADDI, 5'd2, 5'd0, 16'd20);
        dut.MEM[2] = r_i(OP_ADD, 5'd3, 5'd1, 5'd2);
        dut.MEM[3] = r_i(OP_SUB, 5'd4, 5'd3, 5'd1);
        dut.MEM[4] = r_i(OP_MUL, 5'd5, 5'd3, 5'd4);
        dut.MEM[5] = r_i(OP_SLT, 5'd6, 5'd1, 5'd2);
        dut.MEM[6] = HALT_W;
        run("b2b", 100, cyc);
        chk("b2b r3", dut.REG[3], 32'd30);
        chk("b2b r4", dut.REG[4], 32'd20);
        chk("b2b r5", dut.REG[5], 32'd600);
        chk("b2b r6", dut.REG[6], 32'd1);

        // load-use: same shape without the dependency is the timing baseline
        hold_reset();
        dut.MEM[200] = 32'd7;
        dut.MEM[0] = i_i(OP_ADDI, 5'd1, 5'd0, 16'd200);
        dut.MEM[1] = i_i(OP_LW, 5'd2, 5'd1, 16'd0);
        dut.MEM[2] = r_i(OP_ADD, 5'd3, 5'd1, 5'd1);
        dut.MEM[3] = HALT_W;
        run("nodep", 100, cyc_nodep);
        chk("nodep r3", dut.REG[3], 32'd400);
        hold_reset();
        dut.MEM[200] = 32'd7;
        dut.MEM[0] = i_i(OP_ADDI, 5'd1, 5'd0, 16'd200);
        dut.MEM[1] = i_i(OP_LW, 5'd2, 5'd1, 16'd0);
        dut.MEM[2] = r_i(OP_ADD, 5'd3, 5'd2, 5'd2);
        dut.MEM[3] = HALT_W;
        run("loaduse", 100, cyc);
        chk("loaduse r3", dut.REG[3], 32'd14);
        chk("loaduse stall cycles", 32'(cyc - cyc_nodep), 32'd1);
        chk("nodep cycles", 32'(cyc_nodep), 32'd8);

        // factorial loop
        hold_reset();
        load_fact();
        t0 = taken_seen;
        run("fact", 300, cyc);
        chk("fact mem198", dut.MEM[198], 32'd5040);
        chk("fact r3", dut.REG[3], 32'd0);
        chk("fact squash r20", dut.REG[20], 32'd1);
        chk("fact squash r21", dut.REG[21], 32'd1);
        chk("fact taken pulses", 32'(taken_seen - t0), 32'd6);

        // nothing younger than HLT commits; PC freezes
        hold_reset();
        dut.MEM[0] = HALT_W;
        dut.MEM[1] = i_i(OP_ADDI, 5'd1, 5'd0, 16'd99);
        run("hlt", 50, cyc);
        chk("hlt r1", dut.REG[1], 32'd1);
        chk("hlt pc", 32'(dut.PC), 32'd1);
        repeat (5) @(negedge clk);
        chk("hlt pc frozen", 32'(dut.PC), 32'd1);
        chk("hlt sticky", {31'd0, halted}, 32'd1);

        // reset mid-run, after the first loop iteration has committed
        hold_reset();
        load_fact();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst halted", {31'd0, halted}, 32'd0);
        chk("midrst pc", 32'(dut.PC), 32'd0);
        chk("midrst r2 kept", dut.REG[2], 32'd7);
        chk("midrst r3 kept", dut.REG[3], 32'd6);
        chk("midrst mem200", dut.MEM[200], 32'd7);
        chk("midrst mem198", dut.MEM[198], 32'd0);
        run("rerun", 300, cyc);
        chk("rerun mem198", dut.MEM[198], 32'd5040);
        chk("rerun r20", dut.REG[20], 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mips_32.md
Name: mips_32

Overview:
- 5-stage in-order pipelined MIPS32-subset processor: IF, ID, EX, MEM, WB.
- Runs from one unified word-addressed instruction/data memory and a 32x32 register file, both internal.
- Stops itself on HLT.
- Top-level compute core; the bench preloads program, data and registers hierarchically.

Parameters:
- MEM_DEPTH, 1024, number of 32-bit words in the unified memory.
- AW, 10, PC/memory address width; must equal clog2(MEM_DEPTH).

Ports:
- clk  input  1  single system clock; every flop updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- halted  output  1  high once HLT has retired; mirrors internal HALTED.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Hierarchically visible state, with exactly these names:
  - REG[0:31]: 32-bit register file.
  - MEM[0:MEM_DEPTH-1]: 32-bit memory.
  - PC: AW bits.
  - HALTED: 1 bit.
  - TAKEN_BRANCH: 1 bit.
- Reset:
  - Clears PC, HALTED, TAKEN_BRANCH and halted.
  - Turns every pipeline register into a bubble.
  - REG and MEM are NOT cleared, so preloads made during reset are kept.
- Instruction encoding:
  - opcode [31:26], rs [25:21], rt [20:16], rd [15:11], imm [15:0] sign-extended to 32 bits.
  - PC counts words and increments by 1.
- Opcodes:
  - R-type, rd = rs op rt: ADD 0, SUB 1, AND 2, OR 3, SLT 4 (signed, result 1/0), MUL 5 (low 32 bits).
  - Memory: LW 8, rt = MEM[rs+imm]; SW 9, MEM[rs+imm] = rt.
  - Immediate, rt = rs op imm: ADDI 10, SUBI 11, SLTI 12.
  - Branches: BNEQZ 13, BEQZ 14; test rs against zero; target = branch PC + 1 + imm.
  - HLT 63.
  - Any other opcode is a NOP.
- Arithmetic:
  - Wraps modulo 2^32; no overflow trap.
  - Memory address = low AW bits of (rs + imm).
- R0:
  - Writes to R0 are discarded; reads of R0 return 0.
- Hazards: any program executes as if it ran sequentially.
  - Register file is write-through: a WB write is visible to a same-cycle ID read.
  - EX operands are forwarded from EX/MEM (ALU results) and MEM/WB (ALU and load results); the youngest producer wins.
  - Load-use: an LW immediately followed by a consumer of its rt stalls IF/ID for 1 cycle and inserts a bubble into EX.
  - SW store data takes the forwarded rt value.
- Branches:
  - Resolved in EX.
  - Taken: PC loads the target on the next edge, TAKEN_BRANCH pulses for 1 cycle, and the 2 younger instructions in IF/ID are squashed.
  - Squashed instructions do no register or memory write.
  - Not-taken: no penalty.
- Halt:
  - HLT decoded in ID freezes PC; no further fetch.
  - When HLT reaches WB, HALTED and halted go to 1 and stay 1 until reset.
  - Instructions older than HLT complete; nothing younger commits.
  - A HLT squashed by a taken branch has no effect.
- Reset mid-operation:
  - Aborts all in-flight instructions immediately.
  - Writes already committed remain.
  - Execution restarts from PC 0 after rst_n rises.
- Latency: one instruction retires per cycle in steady state; first WB occurs 4 cycles after the first fetch.

Decomposition:
- Package mips_pkg holds:
  - Opcode localparams (ADD..HLT).
  - Instruction-class enum: RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT, NOP.
  - Field-slice constants.
- One natural sub-module: mips_alu.
  - Combinational; inputs opcode, a, b.
  - Outputs 32-bit result and zero flag.
- Register file, memory, forwarding and hazard logic stay in mips_32.

Test Plan:
- Memory/immediate chain with NOP spacers.
  - Preload REG[k]=k, MEM[120]=85.
  - Program: ADDI R1,R0,120; OR R3,R3,R3; LW R2,0(R1); OR; ADDI R2,R2,45; OR; SW R2,1(R1); HLT.
  - Required: MEM[121]=130, MEM[120]=85, R1=120, R2=130, halted=1.
- Back-to-back dependencies, no spacers.
  - ADDI R1,R0,10; ADDI R2,R0,20; ADD R3,R1,R2; SUB R4,R3,R1; MUL R5,R3,R4; SLT R6,R1,R2; HLT.
  - Required: R3=30, R4=20, R5=600, R6=1.
- Load-use stall.
  - MEM[200]=7; ADDI R1,R0,200; LW R2,0(R1); ADD R3,R2,R2; HLT.
  - Required: R3=14; exactly one stall cycle.
- Branch loop (factorial).
  - MEM[200]=7; R10=200.
  - Loop: MUL; SUBI; BNEQZ back.
  - Required: MEM[198]=5040.
  - The 2 instructions after each taken branch are not committed; TAKEN_BRANCH pulses once per taken iteration.
- HLT followed by ADDI R1,R0,99.
  - Required: R1 unchanged, halted=1, PC frozen.
- Assert rst_n low mid-run.
  - Required: halted=0, PC=0; REG/MEM committed values retained; program reruns correctly after release.
